// File: rtl/muldiv_seq.sv
// Sequential radix-2 multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle, WIDTH steps per operation.
module muldiv_seq #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

  state_e               state_q, state_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic                 dz_q, dz_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 busy_q, busy_d, done_q, done_d, divzero_q, divzero_d;

  logic                 signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, div_part, div_diff;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod_s;
  logic [WIDTH-1:0]     quot, rem;

  always_comb begin
    signed_op = SIGNED_EN & op[0];
    a_neg     = signed_op & srca[WIDTH-1];
    b_neg     = signed_op & srcb[WIDTH-1];
    a_mag     = a_neg ? -srca : srca;
    b_mag     = b_neg ? -srcb : srcb;

    // acc holds {partial product, remaining multiplier bits}
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    // acc holds {partial remainder, dividend bits / quotient bits}
    div_part  = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_part - {1'b0, opb_q};
    div_next  = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    prod_s    = neg_q ? -acc_q : acc_q;
    quot      = acc_q[WIDTH-1:0];
    rem       = acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          is_div_d = op[1];
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          cnt_d    = CW'(WIDTH);
          dz_d     = op[1] && (srcb == '0);
          if (op[1]) begin
            acc_d = {{WIDTH{1'b0}}, a_mag};
            opb_d = b_mag;
          end else begin
            acc_d = {{WIDTH{1'b0}}, b_mag};
            opb_d = a_mag;
          end
          state_d = (op[1] && (srcb == '0)) ? S_FIX : S_RUN;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      S_RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        if (!dz_q) begin
          if (is_div_q) begin
            lo_d = neg_q ? -quot : quot;
            hi_d = rneg_q ? -rem : rem;
          end else begin
            hi_d = prod_s[2*WIDTH-1:WIDTH];
            lo_d = prod_s[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d    = (state_d == S_RUN) || (state_d == S_FIX);
    done_d    = (state_d == S_DONE);
    divzero_d = (state_d == S_DONE) && dz_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      dz_q      <= dz_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign divzero = divzero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: vector table plus hand-written corner sequences.
module tb_muldiv_seq;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, mthi, mtlo;
  logic [1:0]   op;
  logic [W-1:0] srca, srcb, wdata;
  logic         busy, done, divzero;
  logic [W-1:0] hi, lo;
  logic         busy_u, done_u, divzero_u;
  logic [W-1:0] hi_u, lo_u;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;
  vec_t vecs[10];

  logic [1:0]   nxt_op;
  logic [W-1:0] nxt_a, nxt_b, nxt_hi, nxt_lo;
  logic [W-1:0] inj_hold;

  muldiv_seq #(.WIDTH(W), .SIGNED_EN(1'b1)) u_dut (
    .clk(clk), .reset(rst_n), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .divzero(divzero), .hi(hi), .lo(lo)
  );

  muldiv_seq #(.WIDTH(W), .SIGNED_EN(1'b0)) u_dut_u (
    .clk(clk), .reset(rst_n), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy_u), .done(done_u),
    .divzero(divzero_u), .hi(hi_u), .lo(lo_u)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz,
                        input logic mh, input logic ml, input logic [W-1:0] wd);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; srca = a; srcb = b; mthi = mh; mtlo = ml; wdata = wd;
    e.hi = eh; e.lo = el; e.dz = edz;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
  endtask

  // n counts negedges after the start edge; done must appear at n == lat
  task automatic wait_done(input string name, input int lat, input int inject_at, input bit b2b);
    int   n = 0;
    int   busy_cnt = 0;
    bit   seen = 1'b0;
    exp_t e, nx;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (n == inject_at) begin
        start = 1'b1; op = 2'b10; srca = 5; srcb = 0; mthi = 1'b1; wdata = 32'h00000BAD;
      end else if (n == inject_at + 1) begin
        start = 1'b0; mthi = 1'b0;
      end
      if (inject_at != 0 && n == inject_at + 2)
        check({name, "_hi_hold"}, 64'(hi), 64'(inj_hold));
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_done required=done_within_%0d", name, lat);
    end else if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_unexpected actual=done required=empty_scoreboard", name);
    end else begin
      e = sb.pop_front();
      check({name, "_latency"}, 64'(n), 64'(lat));
      check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(lat - 1));
      check({name, "_hi"}, 64'(hi), 64'(e.hi));
      check({name, "_lo"}, 64'(lo), 64'(e.lo));
      check({name, "_divzero"}, 64'(divzero), 64'(e.dz));
      if (b2b) begin
        start = 1'b1; op = nxt_op; srca = nxt_a; srcb = nxt_b;
        nx.hi = nxt_hi; nx.lo = nxt_lo; nx.dz = 1'b0;
        sb.push_back(nx);
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        @(negedge clk);
        check({name, "_done_pulse"}, 64'(done), 64'(0));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;

    vecs[0] = '{op: 2'b00, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, hi: 32'hFFFFFFFE, lo: 32'h00000001};
    vecs[1] = '{op: 2'b01, a: 32'hFFFFFFFD, b: 32'h00000005, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFF1};
    vecs[2] = '{op: 2'b11, a: 32'hFFFFFFF9, b: 32'h00000002, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD};
    vecs[3] = '{op: 2'b10, a: 32'd100,      b: 32'd7,        hi: 32'd2,        lo: 32'd14};
    vecs[4] = '{op: 2'b11, a: 32'h80000000, b: 32'hFFFFFFFF, hi: 32'h00000000, lo: 32'h80000000};
    vecs[5] = '{op: 2'b01, a: 32'h7FFFFFFF, b: 32'h7FFFFFFF, hi: 32'h3FFFFFFF, lo: 32'h00000001};
    vecs[6] = '{op: 2'b10, a: 32'hFFFFFFFF, b: 32'h00000010, hi: 32'h0000000F, lo: 32'h0FFFFFFF};
    vecs[7] = '{op: 2'b11, a: 32'h00000007, b: 32'hFFFFFFFE, hi: 32'h00000001, lo: 32'hFFFFFFFD};
    vecs[8] = '{op: 2'b01, a: 32'h80000000, b: 32'h80000000, hi: 32'h40000000, lo: 32'h00000000};
    vecs[9] = '{op: 2'b00, a: 32'h12345678, b: 32'h00000000, hi: 32'h00000000, lo: 32'h00000000};

    repeat (2) @(negedge clk);
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_divzero", 64'(divzero), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0, 1'b0, 1'b0, '0);
      wait_done($sformatf("vec%0d", i), 34, 0, 1'b0);
    end

    // same MULT on the unsigned-only instance
    launch(2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0, 1'b0, '0);
    wait_done("mult_signed", 34, 0, 1'b0);
    check("unsigned_inst_hi", 64'(hi_u), 64'h4);
    check("unsigned_inst_lo", 64'(lo_u), 64'hFFFFFFF1);
    check("unsigned_inst_divzero", 64'(divzero_u), 64'(0));
    check("unsigned_inst_busy", 64'(busy_u), 64'(0));
    check("unsigned_inst_done", 64'(done_u), 64'(0));

    @(negedge clk); mthi = 1'b1; wdata = 32'h1234;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5678;
    @(negedge clk); mtlo = 1'b0;
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mtlo_lo", 64'(lo), 64'h5678);

    launch(2'b10, 32'd100, 32'd0, 32'h1234, 32'h5678, 1'b1, 1'b0, 1'b0, '0);
    wait_done("divzero", 2, 0, 1'b0);

    launch(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0, 1'b1, 32'hDEAD);
    check("start_mtlo_dropped", 64'(lo), 64'h5678);
    wait_done("start_mtlo", 34, 0, 1'b0);

    inj_hold = 32'd0;
    launch(2'b00, 32'h00010000, 32'h00010000, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, '0);
    wait_done("midrun_inject", 34, 10, 1'b0);

    nxt_op = 2'b10; nxt_a = 32'd100; nxt_b = 32'd7; nxt_hi = 32'd2; nxt_lo = 32'd14;
    launch(2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0, 1'b0, '0);
    wait_done("b2b_first", 34, 0, 1'b1);
    wait_done("b2b_second", 34, 0, 1'b0);

    launch(2'b00, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0, 1'b0, 1'b0, '0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_hi", 64'(hi), 64'(0));
    check("midreset_lo", 64'(lo), 64'(0));
    check("midreset_busy", 64'(busy), 64'(0));
    sb.delete();
    @(negedge clk);
    check("midreset_done", 64'(done), 64'(0));
    rst_n = 1'b1;
    launch(2'b11, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 1'b0, 1'b0, '0);
    wait_done("post_reset", 34, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
